// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the sync_fifo family: pointer/level width and
// parameter-legality checks used at elaboration.
package sync_fifo_pkg;

    // Pointers and level carry one extra bit so that full and empty stay distinguishable.
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic bit levels_legal(input int addr_width, input int af_level, input int ae_level);
        int depth;
        depth = 1 << addr_width;
        return (addr_width >= 1) &&
               (af_level >= 1) && (af_level <= depth) &&
               (ae_level >= 0) && (ae_level <= depth - 1);
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping FIFO pointer: the MSB is the lap bit, the low bits index memory.
module fifo_ptr #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] ptr_q
);

    logic [W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = ptr_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sync_fifo_pro.sv
// Single-clock first-word-fall-through FIFO with level count, threshold
// flags, synchronous flush and sticky overflow/underflow errors.
module sync_fifo_pro
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   level,
    input  logic                  err_clr,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int LVL_W = ptr_width(ADDR_WIDTH);

    if (!levels_legal(ADDR_WIDTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_params
        $error("sync_fifo_pro: illegal ADDR_WIDTH/AF_LEVEL/AE_LEVEL combination");
    end

    logic [LVL_W-1:0]      wr_ptr;
    logic [LVL_W-1:0]      rd_ptr;
    logic [LVL_W-1:0]      level_q;
    logic [LVL_W-1:0]      level_d;
    logic                  overflow_q;
    logic                  overflow_d;
    logic                  underflow_q;
    logic                  underflow_d;
    logic                  push;
    logic                  pop;
    fifo_flags_t           flags;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Accept decisions use the pre-edge flags; flush masks both requests.
    assign push = wr_en && !flags.full  && !flush;
    assign pop  = rd_en && !flags.empty && !flush;

    fifo_ptr #(.W(LVL_W)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (push),
        .clr   (flush),
        .ptr_q (wr_ptr)
    );

    fifo_ptr #(.W(LVL_W)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (pop),
        .clr   (flush),
        .ptr_q (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr[ADDR_WIDTH-1:0]] <= data_in;
        end
    end

    always_comb begin
        level_d = level_q;
        if (flush) begin
            level_d = '0;
        end else if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop && !push) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    // Set beats clear; a request that arrives during flush never counts as an error.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (wr_en && flags.full && !flush) begin
            overflow_d = 1'b1;
        end
        if (rd_en && flags.empty && !flush) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_comb begin
        flags              = '0;
        flags.full         = (level_q == LVL_W'(DEPTH));
        flags.empty        = (level_q == '0);
        flags.almost_full  = (level_q >= LVL_W'(AF_LEVEL));
        flags.almost_empty = (level_q <= LVL_W'(AE_LEVEL));
    end

    assign full         = flags.full;
    assign empty        = flags.empty;
    assign almost_full  = flags.almost_full;
    assign almost_empty = flags.almost_empty;
    assign level        = level_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
    assign data_out     = flags.empty ? '0 : mem_q[rd_ptr[ADDR_WIDTH-1:0]];

    level_matches_ptrs: assert property (@(posedge clk) disable iff (!rst_n)
        level_q == (wr_ptr - rd_ptr));

endmodule
